nios_project_led_sequencer: RTL and testbench

Autonomous LED pattern sequencer that drives the 8-bit LED PIO's Avalon-MM s1 slave as a bus master, so software loads a pattern table once instead of writing LEDs in a loop. A CPU-facing Avalon-MM slave holds control, period, length and an 8-entry pattern table. A small FSM issues single-cycle writes of successive patterns to the PIO data register at a programmable interval. Sits in the Qsys system between the Nios data master and the LED PIO.

---
 rtl/nios_project_led_sequencer_if.sv | 37 +++
 rtl/nios_project_led_sequencer.sv | 168 ++++++++++++++++
 tb/tb_nios_project_led_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_project_led_sequencer_if.sv
// Bus bundle for the LED sequencer: CPU-facing Avalon-MM slave
// signals plus the single-cycle write master toward the LED PIO.
interface nios_project_led_sequencer_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output pio_address,
    output pio_chipselect,
    output pio_write_n,
    output pio_writedata
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  pio_address,
    input  pio_chipselect,
    input  pio_write_n,
    input  pio_writedata
  );
endinterface

// File: rtl/nios_project_led_sequencer.sv
// Autonomous LED pattern sequencer mastering the LED PIO s1 slave.
// Optional LED_SEQ_IRQ_EN adds the irq port and the CTRL.irq_en bit.
module nios_project_led_sequencer #(
  parameter int PERIOD_W = 24
) (
  input logic clk,
  input logic reset_n,
  nios_project_led_sequencer_if.slave bus
`ifdef LED_SEQ_IRQ_EN
  ,
  output logic irq
`endif
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT
  } state_t;

  localparam logic [PERIOD_W-1:0] CNT_ONE = 1;

  state_t state_q, state_d;
  logic run_q, oneshot_q, irq_en_q, done_q;
  logic [PERIOD_W-1:0] period_q, cnt_q, cnt_d;
  logic [3:0] length_q;
  logic [7:0] pat_q [8];
  logic [2:0] idx_q, idx_d, last_idx;
  logic set_done, clr_run, wr_en, go_write;
  logic pio_cs_q, pio_wn_q;
  logic [7:0] pio_pat_q;
  logic unused_wd;

  assign wr_en = bus.chipselect && !bus.write_n;
  assign unused_wd = ^bus.writedata;

  always_comb begin
    unique case (1'b1)
      (length_q == 4'd0): last_idx = 3'd0;
      (length_q > 4'd8):  last_idx = 3'd7;
      default:            last_idx = 3'(length_q - 4'd1);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    set_done = 1'b0;
    clr_run  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run_q) begin
          state_d = S_WRITE;
          idx_d   = 3'd0;
        end
      end
      S_WRITE: begin
        if (!run_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = period_q;
        end
      end
      S_WAIT: begin
        if (!run_q) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (idx_q == last_idx) begin
          set_done = 1'b1;
          if (oneshot_q) begin
            clr_run = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = 3'd0;
            state_d = S_WRITE;
          end
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_WRITE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign go_write = (state_d == S_WRITE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      cnt_q     <= '0;
      pio_cs_q  <= 1'b0;
      pio_wn_q  <= 1'b1;
      pio_pat_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      pio_cs_q <= go_write;
      pio_wn_q <= !go_write;
      if (go_write) pio_pat_q <= pat_q[idx_d];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q     <= 1'b0;
      oneshot_q <= 1'b0;
      done_q    <= 1'b0;
      period_q  <= '0;
      length_q  <= 4'd0;
      for (int i = 0; i < 8; i++) pat_q[i] <= 8'd0;
    end else begin
      if (wr_en) begin
        unique case (1'b1)
          (bus.address == 4'd0): begin
            run_q     <= bus.writedata[0];
            oneshot_q <= bus.writedata[1];
          end
          (bus.address == 4'd2): period_q <= bus.writedata[PERIOD_W-1:0];
          (bus.address == 4'd3): length_q <= bus.writedata[3:0];
          bus.address[3]:        pat_q[bus.address[2:0]] <= bus.writedata[7:0];
          default: ;
        endcase
      end
      if (clr_run) run_q <= 1'b0;
      // Hardware set of done beats a simultaneous W1C.
      if (wr_en && bus.address == 4'd1 && bus.writedata[8]) done_q <= 1'b0;
      if (set_done) done_q <= 1'b1;
    end
  end

`ifdef LED_SEQ_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && bus.address == 4'd0) irq_en_q <= bus.writedata[2];
      irq <= done_q && irq_en_q;
    end
  end
`else
  assign irq_en_q = 1'b0;
`endif

  always_comb begin
    bus.readdata = '0;
    unique case (1'b1)
      (bus.address == 4'd0):
        bus.readdata = {29'd0, irq_en_q, oneshot_q, run_q};
      (bus.address == 4'd1):
        bus.readdata = {23'd0, done_q, 1'b0, idx_q, 3'd0, state_q != S_IDLE};
      (bus.address == 4'd2): bus.readdata = 32'(period_q);
      (bus.address == 4'd3): bus.readdata = {28'd0, length_q};
      bus.address[3]:        bus.readdata = {24'd0, pat_q[bus.address[2:0]]};
      default:               bus.readdata = '0;
    endcase
  end

  assign bus.pio_address    = 2'd0;
  assign bus.pio_chipselect = pio_cs_q;
  assign bus.pio_write_n    = pio_wn_q;
  assign bus.pio_writedata  = {24'd0, pio_pat_q};
endmodule

// File: tb/tb_nios_project_led_sequencer.sv
// Self-checking bench for nios_project_led_sequencer: register table,
// directed multi-cycle sequences and randomized runs against a timing model.
module tb_nios_project_led_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nios_project_led_sequencer_if bus();
`ifdef LED_SEQ_IRQ_EN
  logic irq;
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  nios_project_led_sequencer #(.PERIOD_W(24)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef LED_SEQ_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  int tot = 0;
  int bad = 0;
  int cyc = 0;
  int t_wr = 0;
  logic [31:0] r;
  logic [7:0] pats [8];

  typedef struct {
    int c;
    logic [31:0] d;
  } wr_t;
  wr_t wq[$];
  logic prev_stb = 1'b0;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.pio_chipselect && !bus.pio_write_n) begin
      wq.push_back('{cyc, bus.pio_writedata});
      tot++;
      if (prev_stb) begin
        bad++;
        $display("FAIL strobe_width: got 2-cycle strobe at cyc %0d, want 1", cyc);
      end
    end
    prev_stb = bus.pio_chipselect && !bus.pio_write_n;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    t_wr           = cyc;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.address = a;
    #1;
    v = bus.readdata;
  endtask

  task automatic load_pats();
    for (int i = 0; i < 8; i++) cpu_wr(4'(8 + i), {24'd0, pats[i]});
  endtask

  task automatic stop_run();
    cpu_wr(4'd0, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    wq.delete();
    cpu_wr(4'd1, 32'h100);
  endtask

  // Model: write j lands at t0+1+j*(P+2) carrying pattern[j mod L].
  task automatic check_writes(input string nm, input int t0, input int p,
                              input int len, input int n);
    int leff, tend, guard;
    leff  = (len == 0) ? 1 : ((len > 8) ? 8 : len);
    tend  = t0 + 1 + (n - 1) * (p + 2);
    guard = 0;
    while (cyc <= tend + 1 && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk({nm, "_timeout"}, 32'(guard < 5000), 32'd1);
    chk({nm, "_count"}, 32'(wq.size()), 32'(n));
    for (int j = 0; j < n; j++) begin
      if (j < wq.size()) begin
        chk($sformatf("%s_cyc%0d", nm, j), 32'(wq[j].c), 32'(t0 + 1 + j * (p + 2)));
        chk($sformatf("%s_dat%0d", nm, j), wq[j].d, {24'd0, pats[j % leff]});
      end
    end
  endtask

  initial begin
    int t, len, p, leff;
    bus.address    = 4'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;

    vt[0] = '{4'd2,  32'hFFFF_FFFF, 32'h00FF_FFFF};
    vt[1] = '{4'd3,  32'hFFFF_FFFF, 32'h0000_000F};
    vt[2] = '{4'd8,  32'h0000_1234, 32'h0000_0034};
    vt[3] = '{4'd15, 32'h0000_ABCD, 32'h0000_00CD};
    vt[4] = '{4'd4,  32'h0000_FFFF, 32'h0000_0000};
    vt[5] = '{4'd1,  32'hFFFF_FFFF, 32'h0000_0000};
    vt[6] = '{4'd0,  32'h0000_0006, IRQ ? 32'd6 : 32'd2};
    vt[7] = '{4'd7,  32'h0000_0055, 32'h0000_0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_pio_write_n", 32'(bus.pio_write_n), 32'd1);
    chk("rst_pio_cs", 32'(bus.pio_chipselect), 32'd0);
    chk("rst_pio_addr", 32'(bus.pio_address), 32'd0);
    chk("rst_pio_data", bus.pio_writedata, 32'd0);
`ifdef LED_SEQ_IRQ_EN
    chk("rst_irq", 32'(irq), 32'd0);
`endif
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), r);
      chk($sformatf("rst_rd%0d", a), r, 32'd0);
    end

    for (int k = 0; k < 8; k++) begin
      cpu_wr(vt[k].a, vt[k].wd);
      rd(vt[k].a, r);
      chk($sformatf("regtab%0d", k), r, vt[k].exp);
    end
    cpu_wr(4'd0, 32'd0);

    // Looping run, PERIOD=3, LENGTH=4
    pats = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
    load_pats();
    wq.delete();
    cpu_wr(4'd3, 32'd4);
    cpu_wr(4'd2, 32'd3);
    cpu_wr(4'd0, 32'd1);
    t = t_wr;
    check_writes("loop", t, 3, 4, 5);
    rd(4'd1, r);
    chk("loop_done", 32'(r[8]), 32'd1);
    chk("loop_busy", 32'(r[0]), 32'd1);
    stop_run();

    // Oneshot, LENGTH=2
    cpu_wr(4'd3, 32'd2);
    cpu_wr(4'd0, IRQ ? 32'd7 : 32'd3);
    t = t_wr;
    check_writes("oneshot", t, 3, 2, 2);
    repeat (15) @(posedge clk);
    #1;
    chk("oneshot_final_count", 32'(wq.size()), 32'd2);
    rd(4'd0, r);
    chk("oneshot_ctrl", r, IRQ ? 32'd6 : 32'd2);
    rd(4'd1, r);
    chk("oneshot_done", 32'(r[8]), 32'd1);
    chk("oneshot_busy", 32'(r[0]), 32'd0);
`ifdef LED_SEQ_IRQ_EN
    chk("irq_high", 32'(irq), 32'd1);
    cpu_wr(4'd1, 32'h100);
    chk("irq_lag", 32'(irq), 32'd1);
    @(posedge clk);
    #1;
    chk("irq_cleared", 32'(irq), 32'd0);
`endif
    stop_run();

    // Stop mid-WAIT with a long period
    cpu_wr(4'd2, 32'd100);
    cpu_wr(4'd3, 32'd4);
    cpu_wr(4'd0, 32'd1);
    repeat (20) @(posedge clk);
    cpu_wr(4'd0, 32'd0);
    @(posedge clk);
    rd(4'd1, r);
    chk("stop_busy", 32'(r[0]), 32'd0);
    repeat (250) @(posedge clk);
    #1;
    chk("stop_count", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) chk("stop_first", wq[0].d, 32'h01);
    chk("stop_led_hold", bus.pio_writedata, 32'h01);
    stop_run();

    // LENGTH=0, PERIOD=0: pattern 0 every 2 cycles
    pats[0] = 8'hA5;
    cpu_wr(4'd8, 32'hA5);
    cpu_wr(4'd2, 32'd0);
    cpu_wr(4'd3, 32'd0);
    cpu_wr(4'd0, 32'd1);
    check_writes("fast", t_wr, 0, 0, 4);
    stop_run();

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 8; i++) pats[i] = 8'($urandom);
      load_pats();
      len  = int'($urandom_range(0, 15));
      p    = int'($urandom_range(0, 6));
      leff = (len == 0) ? 1 : ((len > 8) ? 8 : len);
      cpu_wr(4'd3, 32'(len));
      cpu_wr(4'd2, 32'(p));
      wq.delete();
      cpu_wr(4'd0, 32'd1);
      check_writes($sformatf("rnd%0d", it), t_wr, p, len, leff + 2);
      stop_run();
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
